pheap_insert_stage: RTL and testbench

PHEAP_INSERT_STAGE -- requirements
Module: pheap_insert_stage

---
 rtl/pheap_insert_stage.sv | 128 ++++++++++++
 tb/tb_pheap_insert_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pheap_insert_stage.sv
// pheap_insert_stage: one level of a pipelined min-heap insert path.
//   Reads the node addressed by the incoming token, keeps the smaller key,
//   rewrites the node with updated free-slot counts and forwards the larger
//   key toward the child subtree that still has room.
//   Optional feature: define PHEAP_INSERT_STATS_EN to add o_ins_count.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_in_valid/o_in_ready       upstream insert handshake
//   i_in_key, i_in_idx          key and node index within this level
//   o_out_valid/i_out_ready     downstream insert handshake
//   o_out_key, o_out_idx        pushed key and child index {node idx, dir}
//   o_ram_raddr, i_ram_q        level RAM read port (one-cycle latency)
//   o_ram_we/waddr/wdata        level RAM write port
//   o_ovf                       one-cycle pulse when an insert is dropped
//   o_ins_count                 accepted-insert counter (stats build only)
module pheap_insert_stage #(
    parameter int LEVEL  = 2,
    parameter int LEVELS = 4,
    parameter int KEY_W  = 16,
    parameter int CNT_W  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  logic [KEY_W-1:0]             i_in_key,
    input  logic [LEVEL-2:0]             i_in_idx,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [KEY_W-1:0]             o_out_key,
    output logic [LEVEL-1:0]             o_out_idx,
    output logic [LEVEL-2:0]             o_ram_raddr,
    input  logic [KEY_W+2*CNT_W:0]       i_ram_q,
    output logic                         o_ram_we,
    output logic [LEVEL-2:0]             o_ram_waddr,
    output logic [KEY_W+2*CNT_W:0]       o_ram_wdata,
`ifdef PHEAP_INSERT_STATS_EN
    output logic [15:0]                  o_ins_count,
`endif
    output logic                         o_ovf
);
    localparam int ENTRY_W = 1 + KEY_W + 2 * CNT_W;
    localparam int D = LEVELS - LEVEL;
    localparam bit LAST = (LEVEL == LEVELS);
    // Free slots in each child subtree of a fresh node, clipped to the count width.
    localparam logic [CNT_W-1:0] F = (D >= CNT_W) ? {CNT_W{1'b1}} : CNT_W'((64'd1 << D) - 64'd1);
    typedef enum logic [1:0] {IDLE, EVAL, SEND} state_t;
    state_t             r_state;
    logic [KEY_W-1:0]   r_key;
    logic [LEVEL-2:0]   r_idx;
    logic               w_vld;
    logic [KEY_W-1:0]   w_nkey;
    logic [CNT_W-1:0]   w_cl;
    logic [CNT_W-1:0]   w_cr;
    logic               w_drop;
    logic               w_keep_in;
    logic [KEY_W-1:0]   w_kept;
    logic [KEY_W-1:0]   w_push;
    logic               w_dir;
    logic [CNT_W-1:0]   w_cl_n;
    logic [CNT_W-1:0]   w_cr_n;
    logic               w_we;
    assign w_vld     = i_ram_q[ENTRY_W-1];
    assign w_nkey    = i_ram_q[ENTRY_W-2 -: KEY_W];
    assign w_cl      = i_ram_q[2*CNT_W-1 -: CNT_W];
    assign w_cr      = i_ram_q[CNT_W-1:0];
    // An occupied node cannot absorb the token when nothing lies below it.
    assign w_drop    = w_vld && (LAST || (w_cl == '0 && w_cr == '0));
    assign w_keep_in = r_key <= w_nkey;
    assign w_kept    = w_keep_in ? r_key : w_nkey;
    assign w_push    = w_keep_in ? w_nkey : r_key;
    assign w_dir     = (w_cl == '0);
    assign w_cl_n    = w_dir ? w_cl : w_cl - 1'b1;
    assign w_cr_n    = w_dir ? w_cr - 1'b1 : w_cr;
    // The write is combinational in EVAL so that reset removes it at once.
    assign w_we        = (r_state == EVAL) && !w_drop;
    assign o_ram_we    = w_we;
    assign o_ram_waddr = r_idx;
    assign o_ram_wdata = !w_we ? '0 : !w_vld ? {1'b1, r_key, F, F} : {1'b1, w_kept, w_cl_n, w_cr_n};
    assign o_ram_raddr = (r_state == IDLE) ? i_in_idx : r_idx;
    assign o_in_ready  = (r_state == IDLE);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_key       <= '0;
            r_idx       <= '0;
            o_out_valid <= 1'b0;
            o_out_key   <= '0;
            o_out_idx   <= '0;
            o_ovf       <= 1'b0;
`ifdef PHEAP_INSERT_STATS_EN
            o_ins_count <= '0;
`endif
        end else begin
            o_ovf <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        r_key   <= i_in_key;
                        r_idx   <= i_in_idx;
                        r_state <= EVAL;
`ifdef PHEAP_INSERT_STATS_EN
                        o_ins_count <= (o_ins_count == 16'hFFFF) ? o_ins_count : o_ins_count + 16'd1;
`endif
                    end
                end
                EVAL: begin
                    o_ovf <= w_drop;
                    if (w_vld && !w_drop) begin
                        o_out_key   <= w_push;
                        o_out_idx   <= {r_idx, w_dir};
                        o_out_valid <= 1'b1;
                        r_state     <= SEND;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SEND: begin
                    if (i_out_ready) begin
                        o_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pheap_insert_stage.sv
// tb_pheap_insert_stage: directed checks of pheap_insert_stage with a behavioural level RAM.
module tb_pheap_insert_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    int n_chk = 0;
    int n_err = 0;
    logic        a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
    logic [15:0] a_in_key = 0, a_out_key;
    logic [0:0]  a_in_idx = 0, a_raddr, a_waddr;
    logic [1:0]  a_out_idx;
    logic [32:0] a_q, a_wdata;
    logic        a_we, a_ovf;
    logic [32:0] a_mem [2];
    logic        a_ld = 0;
    logic [0:0]  a_ld_addr = 0;
    logic [32:0] a_ld_data = 0;
    int          a_wcnt = 0;
`ifdef PHEAP_INSERT_STATS_EN
    logic [15:0] a_cnt;
    logic [15:0] b_cnt;
`endif
    logic        b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1;
    logic [15:0] b_in_key = 0, b_out_key;
    logic [2:0]  b_in_idx = 0, b_raddr, b_waddr;
    logic [3:0]  b_out_idx;
    logic [32:0] b_q, b_wdata;
    logic        b_we, b_ovf;
    logic [32:0] b_mem [8];
    int          b_wcnt = 0;
    pheap_insert_stage #(.LEVEL(2), .LEVELS(4), .KEY_W(16), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(a_in_valid), .o_in_ready(a_in_ready), .i_in_key(a_in_key), .i_in_idx(a_in_idx),
        .o_out_valid(a_out_valid), .i_out_ready(a_out_ready), .o_out_key(a_out_key), .o_out_idx(a_out_idx),
        .o_ram_raddr(a_raddr), .i_ram_q(a_q), .o_ram_we(a_we), .o_ram_waddr(a_waddr), .o_ram_wdata(a_wdata),
`ifdef PHEAP_INSERT_STATS_EN
        .o_ins_count(a_cnt),
`endif
        .o_ovf(a_ovf));
    pheap_insert_stage #(.LEVEL(4), .LEVELS(4), .KEY_W(16), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(b_in_valid), .o_in_ready(b_in_ready), .i_in_key(b_in_key), .i_in_idx(b_in_idx),
        .o_out_valid(b_out_valid), .i_out_ready(b_out_ready), .o_out_key(b_out_key), .o_out_idx(b_out_idx),
        .o_ram_raddr(b_raddr), .i_ram_q(b_q), .o_ram_we(b_we), .o_ram_waddr(b_waddr), .o_ram_wdata(b_wdata),
`ifdef PHEAP_INSERT_STATS_EN
        .o_ins_count(b_cnt),
`endif
        .o_ovf(b_ovf));
    always @(posedge clk) begin
        if (a_ld) a_mem[a_ld_addr] <= a_ld_data;
        else if (a_we) begin
            a_mem[a_waddr] <= a_wdata;
            a_wcnt <= a_wcnt + 1;
        end
        a_q <= a_mem[a_raddr];
    end
    always @(posedge clk) begin
        if (b_we) begin
            b_mem[b_waddr] <= b_wdata;
            b_wcnt <= b_wcnt + 1;
        end
        b_q <= b_mem[b_raddr];
    end
    function automatic logic [32:0] ent(input logic v, input logic [15:0] k, input logic [7:0] l, input logic [7:0] r);
        return {v, k, l, r};
    endfunction
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic a_load(input logic [0:0] addr, input logic [32:0] data);
        a_ld = 1; a_ld_addr = addr; a_ld_data = data;
        tick();
        a_ld = 0;
    endtask
    task automatic a_send(input logic [15:0] key, input logic [0:0] idx);
        a_in_valid = 1; a_in_key = key; a_in_idx = idx;
        chk("a_ready_before_accept", a_in_ready, 1);
        tick();
        a_in_valid = 0;
    endtask
    initial begin
        int w0;
        for (int i = 0; i < 8; i++) b_mem[i] = '0;
        a_load(0, '0);
        a_load(1, '0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_ram_we", a_we, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_out_key", a_out_key, 0);
        chk("rst_out_idx", a_out_idx, 0);
        chk("rst_wdata", a_wdata, 0);
        rst_n = 1;
        tick();
        // empty node takes the key with full counts
        w0 = a_wcnt;
        a_send(16'd5, 0);
        chk("t1_we", a_we, 1);
        chk("t1_waddr", a_waddr, 0);
        chk("t1_wdata", a_wdata, ent(1, 5, 3, 3));
        chk("t1_ready_eval", a_in_ready, 0);
        tick();
        chk("t1_out_valid", a_out_valid, 0);
        chk("t1_ready_idle", a_in_ready, 1);
        chk("t1_we_idle", a_we, 0);
        chk("t1_one_write", a_wcnt - w0, 1);
        chk("t1_mem", a_mem[0], ent(1, 5, 3, 3));
        // smaller key displaces stored key to the left child
        a_out_ready = 1;
        a_send(16'd2, 0);
        chk("t2_wdata", a_wdata, ent(1, 2, 2, 3));
        chk("t2_valid_eval", a_out_valid, 0);
        tick();
        chk("t2_out_valid", a_out_valid, 1);
        chk("t2_out_key", a_out_key, 5);
        chk("t2_out_idx", a_out_idx, 2'b00);
        chk("t2_we_send", a_we, 0);
        tick();
        chk("t2_done", a_out_valid, 0);
        chk("t2_ready", a_in_ready, 1);
        // left full: go right; stall downstream
        a_out_ready = 0;
        a_load(0, ent(1, 2, 0, 1));
        a_send(16'd9, 0);
        chk("t3_wdata", a_wdata, ent(1, 2, 0, 0));
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", a_out_valid, 1);
            chk("t3_hold_key", a_out_key, 9);
            chk("t3_hold_idx", a_out_idx, 2'b01);
            chk("t3_hold_ready", a_in_ready, 0);
            tick();
        end
        a_out_ready = 1;
        chk("t3_valid_hs", a_out_valid, 1);
        tick();
        chk("t3_after_hs", a_out_valid, 0);
        // no free slot below: overflow, no write
        w0 = a_wcnt;
        a_send(16'd7, 0);
        chk("t4_we", a_we, 0);
        tick();
        chk("t4_ovf", a_ovf, 1);
        chk("t4_out_valid", a_out_valid, 0);
        tick();
        chk("t4_ovf_clear", a_ovf, 0);
        chk("t4_no_write", a_wcnt - w0, 0);
        chk("t4_mem", a_mem[0], ent(1, 2, 0, 0));
        // back-to-back with in_valid held; second is an equal-key insert
        a_in_valid = 1; a_in_key = 16'd4; a_in_idx = 1;
        chk("t5_ready0", a_in_ready, 1);
        tick();
        chk("t5_ready1", a_in_ready, 0);
        chk("t5_wdata1", a_wdata, ent(1, 4, 3, 3));
        tick();
        chk("t5_ready2", a_in_ready, 1);
        tick();
        a_in_valid = 0;
        chk("t5_ready3", a_in_ready, 0);
        chk("t5_wdata2", a_wdata, ent(1, 4, 2, 3));
        tick();
        chk("t5_out_key", a_out_key, 4);
        chk("t5_out_idx", a_out_idx, 2'b10);
        chk("t5_out_valid", a_out_valid, 1);
        tick();
        chk("t5_idle", a_in_ready, 1);
        // last stage: empty node written with zero counts, occupied node overflows
        b_in_valid = 1; b_in_key = 16'd7; b_in_idx = 3;
        tick();
        b_in_valid = 0;
        chk("b_wdata", b_wdata, ent(1, 7, 0, 0));
        chk("b_waddr", b_waddr, 3);
        tick();
        w0 = b_wcnt;
        b_in_valid = 1;
        tick();
        b_in_valid = 0;
        chk("b_we_full", b_we, 0);
        tick();
        chk("b_ovf", b_ovf, 1);
        chk("b_out_valid", b_out_valid, 0);
        tick();
        chk("b_ovf_clear", b_ovf, 0);
        chk("b_no_write", b_wcnt - w0, 0);
        // reset during EVAL abandons the write
        w0 = a_wcnt;
        a_send(16'd1, 1);
        chk("r_we_eval", a_we, 1);
`ifdef PHEAP_INSERT_STATS_EN
        chk("r_count", a_cnt, 7);
`endif
        rst_n = 0;
        #1;
        chk("r_we_async", a_we, 0);
        chk("r_ready_async", a_in_ready, 1);
        tick();
        rst_n = 1;
        tick();
        chk("r_ready_release", a_in_ready, 1);
        chk("r_out_valid", a_out_valid, 0);
        chk("r_no_write", a_wcnt - w0, 0);
        chk("r_mem", a_mem[1], ent(1, 4, 2, 3));
`ifdef PHEAP_INSERT_STATS_EN
        chk("r_count_zero", a_cnt, 0);
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
